// File: rtl/datapath_param.sv
// datapath_param: parametrised single-bus register datapath with iterative multiplier and memory handshake
// Encoded bus source/GPR destination selects, optional hard-wired zero GPR0.
module datapath_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int IMM_W    = 19,
    parameter bit R0_ZERO  = 1'b1,
    localparam int SRC_W   = $clog2(NUM_REGS + 8),
    localparam int RW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [SRC_W-1:0]  src_sel,
    input  logic              reg_wr_en,
    input  logic [RW-1:0]     reg_wr_sel,
    input  logic              pc_in,
    input  logic              ir_in,
    input  logic              y_in,
    input  logic              hi_in,
    input  logic              lo_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              z_in,
    input  logic [2:0]        alu_op,
    input  logic              alu_start,
    output logic              alu_busy,
    output logic              alu_done,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_done,
    input  logic [DATA_W-1:0] inport_data,
    input  logic [IMM_W-1:0]  c_imm,
    output logic [DATA_W-1:0] bus_data,
    output logic [DATA_W-1:0] pc_data,
    output logic [DATA_W-1:0] ir_data
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_st_e;

    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [DATA_W-1:0] pc_q, ir_q, y_q, hi_q, lo_q, mar_q, mdr_q, zhi_q, zlo_q;
    logic [DATA_W-1:0] mcand_q;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W:0] sum_d;
    logic [CW-1:0] cnt_q;
    logic busy_q, done_q, req_q, we_q, mdone_q;
    mem_st_e st_q;
    logic [DATA_W-1:0] src_v [NUM_REGS+8];
    logic [DATA_W-1:0] bus, alu_d;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) src_v[i] = gpr_q[i];
        src_v[0] = R0_ZERO ? '0 : gpr_q[0];
        src_v[NUM_REGS+0] = hi_q;
        src_v[NUM_REGS+1] = lo_q;
        src_v[NUM_REGS+2] = zhi_q;
        src_v[NUM_REGS+3] = zlo_q;
        src_v[NUM_REGS+4] = pc_q;
        src_v[NUM_REGS+5] = mdr_q;
        src_v[NUM_REGS+6] = inport_data;
        src_v[NUM_REGS+7] = {{(DATA_W-IMM_W){c_imm[IMM_W-1]}}, c_imm};
        bus = ({1'b0, src_sel} < (SRC_W+1)'(NUM_REGS + 8)) ? src_v[src_sel] : '0;
    end

    always_comb begin
        case (alu_op)
            3'd0:    alu_d = y_q + bus;
            3'd1:    alu_d = y_q - bus;
            3'd2:    alu_d = y_q & bus;
            3'd3:    alu_d = y_q | bus;
            3'd4:    alu_d = ~bus;
            3'd5:    alu_d = -bus;
            default: alu_d = bus;
        endcase
    end

    // One shift-add step: conditionally add multiplicand to the high half, then shift right with carry.
    assign sum_d  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + {1'b0, prod_q[0] ? mcand_q : '0};
    assign prod_d = {sum_d, prod_q[DATA_W-1:1]};

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
            pc_q    <= '0;
            ir_q    <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            mdone_q <= 1'b0;
            st_q    <= IDLE;
        end else begin
            if (reg_wr_en && !(R0_ZERO && reg_wr_sel == '0)) gpr_q[reg_wr_sel] <= bus;
            if (pc_in) pc_q <= bus;
            if (ir_in) ir_q <= bus;
            if (y_in) y_q <= bus;
            if (hi_in) hi_q <= bus;
            if (lo_in) lo_q <= bus;
            if (mar_in) mar_q <= bus;
            if (mdr_in) mdr_q <= bus;
            done_q  <= 1'b0;
            mdone_q <= 1'b0;
            if (busy_q) begin
                prod_q <= prod_d;
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_W - 1)) begin
                    {zhi_q, zlo_q} <= prod_d;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else begin
                if (z_in) begin
                    zlo_q <= alu_d;
                    zhi_q <= '0;
                end
                if (alu_start && alu_op == 3'd6) begin
                    prod_q  <= {{DATA_W{1'b0}}, bus};
                    mcand_q <= y_q;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            end
            case (st_q)
                IDLE: begin
                    if (mem_rd || mem_wr) begin
                        st_q  <= mem_rd ? RD_WAIT : WR_WAIT;
                        req_q <= 1'b1;
                        we_q  <= !mem_rd;
                    end
                end
                default: begin
                    if (mem_ready) begin
                        if (st_q == RD_WAIT) mdr_q <= mem_rdata;
                        st_q    <= IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        mdone_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus_data  = bus;
    assign pc_data   = pc_q;
    assign ir_data   = ir_q;
    assign alu_busy  = busy_q;
    assign alu_done  = done_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_done  = mdone_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
endmodule
